ysyx_22041071_axi_r_burst: RTL and testbench

Parametrised AXI4 read master, successor to the single-beat CPU read bridge. It serves two request modes from one CPU-side port. Single mode is a narrow read of 1/2/4/8 bytes, returned right-aligned and zero-extended. Line mode is an INCR burst of LINE_BEATS beats, assembled into one cache-line refill buffer. It sits between the ICache/DCache miss logic and the AXI crossbar. Only one transaction is outstanding at a time.

---
 rtl/ysyx_22041071_axi_r_burst.sv | 189 ++++++++++++++++++
 tb/tb_ysyx_22041071_axi_r_burst.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_axi_r_burst.sv
// AXI4 read master: single narrow reads (right-aligned, zero-extended) or
// INCR line refills assembled into one buffer; one transaction in flight.
module ysyx_22041071_axi_r_burst #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int ID_W       = 4,
  parameter int LINE_BEATS = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cpu_ar_valid,
  output logic                         cpu_ar_ready,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [2:0]                   cpu_size,
  input  logic                         cpu_line,
  input  logic [ID_W-1:0]              cpu_id,
  output logic                         cpu_r_valid,
  output logic [DATA_W-1:0]            cpu_r_data,
  output logic [DATA_W*LINE_BEATS-1:0] cpu_r_line,
  output logic [1:0]                   cpu_r_resp,
  output logic                         axi_ar_valid_o,
  input  logic                         axi_ar_ready_i,
  output logic [ID_W-1:0]              axi_ar_id_o,
  output logic [ADDR_W-1:0]            axi_ar_addr_o,
  output logic [7:0]                   axi_ar_len_o,
  output logic [2:0]                   axi_ar_size_o,
  output logic [1:0]                   axi_ar_burst_o,
  output logic                         axi_r_ready_o,
  input  logic                         axi_r_valid_i,
  input  logic [1:0]                   axi_r_resp_i,
  input  logic [DATA_W-1:0]            axi_r_data_i,
  input  logic                         axi_r_last_i,
  input  logic [ID_W-1:0]              axi_r_id_i
);
  localparam int BYTES   = DATA_W / 8;
  localparam int OFF_W   = $clog2(BYTES);
  localparam int LINE_SH = $clog2(BYTES * LINE_BEATS);
  localparam int IDX_W   = $clog2(LINE_BEATS);
  localparam int CNT_W   = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                      state_q, state_d;
  logic                        ar_ready_q, ar_ready_d;
  logic                        ar_valid_q, ar_valid_d;
  logic                        r_ready_q, r_ready_d;
  logic                        r_valid_q, r_valid_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [7:0]                  len_q, len_d;
  logic [2:0]                  size_q, size_d;
  logic                        line_q, line_d;
  logic [ID_W-1:0]             id_q, id_d;
  logic [OFF_W-1:0]            off_q, off_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [1:0]                  acc_q, acc_d;
  logic [DATA_W-1:0]           data_q, data_d;
  logic [DATA_W*LINE_BEATS-1:0] buf_q, buf_d;
  logic [1:0]                  resp_q, resp_d;

  logic                        beat_hit;
  logic                        counted;
  logic [DATA_W-1:0]           shifted;
  logic [DATA_W-1:0]           mask;
  logic [10:0]                 mask_bits;
  logic [1:0]                  resp_max;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    line_d    = line_q;
    id_d      = id_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    data_d    = data_q;
    buf_d     = buf_q;
    resp_d    = resp_q;
    counted   = 1'b0;
    beat_hit  = r_ready_q && axi_r_valid_i && (axi_r_id_i == id_q);
    shifted   = axi_r_data_i >> {off_q, 3'b000};
    mask_bits = 11'd8 << size_q;
    mask      = ~({DATA_W{1'b1}} << mask_bits);
    resp_max  = (axi_r_resp_i > acc_q) ? axi_r_resp_i : acc_q;

    case (state_q)
      IDLE: begin
        if (cpu_ar_valid && ar_ready_q) begin
          line_d = cpu_line;
          id_d   = cpu_id;
          off_d  = cpu_addr[OFF_W-1:0];
          cnt_d  = '0;
          acc_d  = 2'b00;
          if (cpu_line) begin
            addr_d = cpu_addr & ~((ADDR_W'(1) << LINE_SH) - ADDR_W'(1));
            len_d  = 8'(LINE_BEATS - 1);
            size_d = 3'(OFF_W);
          end else begin
            addr_d = cpu_addr & ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
            len_d  = 8'd0;
            size_d = (cpu_size > 3'(OFF_W)) ? 3'(OFF_W) : cpu_size;
          end
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ar_valid_q && axi_ar_ready_i) state_d = DATA;
      end
      DATA: begin
        if (beat_hit) begin
          if (line_q) begin
            // Extra beats past the line end are dropped; counter saturates.
            if (cnt_q < CNT_W'(LINE_BEATS)) begin
              buf_d[DATA_W*int'(cnt_q[IDX_W-1:0]) +: DATA_W] = axi_r_data_i;
              cnt_d   = cnt_q + CNT_W'(1);
              counted = 1'b1;
            end
          end else begin
            data_d  = shifted & mask;
            counted = 1'b1;
          end
          if (counted) acc_d = resp_max;
          if (axi_r_last_i) begin
            resp_d  = (line_q && cnt_d != CNT_W'(LINE_BEATS)) ? 2'b10 : acc_d;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ar_ready_d = (state_d == IDLE);
    ar_valid_d = (state_d == ADDR);
    r_ready_d  = (state_d == DATA);
    r_valid_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ar_ready_q <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      line_q     <= 1'b0;
      id_q       <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      buf_q      <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      ar_ready_q <= ar_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      r_valid_q  <= r_valid_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      line_q     <= line_d;
      id_q       <= id_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      buf_q      <= buf_d;
      resp_q     <= resp_d;
    end
  end

  assign cpu_ar_ready   = ar_ready_q;
  assign cpu_r_valid    = r_valid_q;
  assign cpu_r_data     = data_q;
  assign cpu_r_line     = buf_q;
  assign cpu_r_resp     = resp_q;
  assign axi_ar_valid_o = ar_valid_q;
  assign axi_ar_id_o    = id_q;
  assign axi_ar_addr_o  = addr_q;
  assign axi_ar_len_o   = len_q;
  assign axi_ar_size_o  = size_q;
  assign axi_ar_burst_o = 2'b01;
  assign axi_r_ready_o  = r_ready_q;
endmodule

// File: tb/tb_ysyx_22041071_axi_r_burst.sv
// Directed bench for ysyx_22041071_axi_r_burst with DATA_W=64, LINE_BEATS=4.
module tb_ysyx_22041071_axi_r_burst;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         cpu_ar_valid;
  logic         cpu_ar_ready;
  logic [63:0]  cpu_addr;
  logic [2:0]   cpu_size;
  logic         cpu_line;
  logic [3:0]   cpu_id;
  logic         cpu_r_valid;
  logic [63:0]  cpu_r_data;
  logic [255:0] cpu_r_line;
  logic [1:0]   cpu_r_resp;
  logic         axi_ar_valid_o;
  logic         axi_ar_ready_i;
  logic [3:0]   axi_ar_id_o;
  logic [63:0]  axi_ar_addr_o;
  logic [7:0]   axi_ar_len_o;
  logic [2:0]   axi_ar_size_o;
  logic [1:0]   axi_ar_burst_o;
  logic         axi_r_ready_o;
  logic         axi_r_valid_i;
  logic [1:0]   axi_r_resp_i;
  logic [63:0]  axi_r_data_i;
  logic         axi_r_last_i;
  logic [3:0]   axi_r_id_i;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_22041071_axi_r_burst #(
    .DATA_W(64), .ADDR_W(64), .ID_W(4), .LINE_BEATS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_ar_valid(cpu_ar_valid), .cpu_ar_ready(cpu_ar_ready),
    .cpu_addr(cpu_addr), .cpu_size(cpu_size), .cpu_line(cpu_line), .cpu_id(cpu_id),
    .cpu_r_valid(cpu_r_valid), .cpu_r_data(cpu_r_data), .cpu_r_line(cpu_r_line),
    .cpu_r_resp(cpu_r_resp),
    .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
    .axi_ar_id_o(axi_ar_id_o), .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_len_o(axi_ar_len_o),
    .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o),
    .axi_r_ready_o(axi_r_ready_o), .axi_r_valid_i(axi_r_valid_i),
    .axi_r_resp_i(axi_r_resp_i), .axi_r_data_i(axi_r_data_i),
    .axi_r_last_i(axi_r_last_i), .axi_r_id_i(axi_r_id_i)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting on DUT", tag);
  endtask

  task automatic do_req(input logic [63:0] addr, input logic [2:0] size,
                        input logic line, input logic [3:0] id);
    int i;
    for (i = 0; i < 20 && !cpu_ar_ready; i++) @(negedge clk);
    if (!cpu_ar_ready) timeout("req_ready");
    cpu_addr = addr; cpu_size = size; cpu_line = line; cpu_id = id;
    cpu_ar_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_ar_valid = 1'b0;
  endtask

  task automatic do_ar(input int delay, input logic [63:0] exp_addr, input logic [7:0] exp_len,
                       input logic [2:0] exp_size, input logic [3:0] exp_id);
    int i;
    for (i = 0; i < 20 && !axi_ar_valid_o; i++) @(negedge clk);
    if (!axi_ar_valid_o) timeout("ar_valid");
    check_val("ar_addr", axi_ar_addr_o, exp_addr);
    check_val("ar_len", axi_ar_len_o, exp_len);
    check_val("ar_size", axi_ar_size_o, exp_size);
    check_val("ar_id", axi_ar_id_o, exp_id);
    check_val("ar_burst", axi_ar_burst_o, 2'b01);
    for (int d = 0; d < delay; d++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("ar_hold_valid", axi_ar_valid_o, 1'b1);
      check_val("ar_hold_addr", axi_ar_addr_o, exp_addr);
    end
    axi_ar_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_ar_ready_i = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] data, input logic [1:0] resp,
                           input logic last, input logic [3:0] id);
    int i;
    for (i = 0; i < 20 && !axi_r_ready_o; i++) @(negedge clk);
    if (!axi_r_ready_o) timeout("r_ready");
    axi_r_valid_i = 1'b1; axi_r_data_i = data; axi_r_resp_i = resp;
    axi_r_last_i = last; axi_r_id_i = id;
    @(posedge clk);
    @(negedge clk);
    axi_r_valid_i = 1'b0; axi_r_last_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 20 && !cpu_r_valid; i++) @(negedge clk);
    check_val({tag, "_valid"}, cpu_r_valid, 1'b1);
    $display("txn %s: resp=%0d data=%h line=%h", tag, cpu_r_resp, cpu_r_data, cpu_r_line);
    @(negedge clk);
    check_val({tag, "_pulse_end"}, cpu_r_valid, 1'b0);
  endtask

  localparam logic [63:0] SD = 64'h1122334455667788;

  initial begin
    reset_n = 1'b0; cpu_ar_valid = 1'b0; cpu_addr = '0; cpu_size = '0; cpu_line = 1'b0;
    cpu_id = '0; axi_ar_ready_i = 1'b0; axi_r_valid_i = 1'b0; axi_r_resp_i = '0;
    axi_r_data_i = '0; axi_r_last_i = 1'b0; axi_r_id_i = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ar_ready", cpu_ar_ready, 1'b0);
    check_val("rst_r_valid", cpu_r_valid, 1'b0);
    check_val("rst_ar_valid", axi_ar_valid_o, 1'b0);
    check_val("rst_r_ready", axi_r_ready_o, 1'b0);
    check_val("rst_line", cpu_r_line, 256'h0);
    reset_n = 1'b1;

    // 1: byte read at offset 5
    do_req(64'h8000_0005, 3'd0, 1'b0, 4'd1);
    check_val("busy_ar_ready", cpu_ar_ready, 1'b0);
    do_ar(0, 64'h8000_0000, 8'd0, 3'd0, 4'd1);
    send_beat(SD, 2'b00, 1'b1, 4'd1);
    wait_done("t1");
    check_val("t1_data", cpu_r_data, 64'h33);
    check_val("t1_resp", cpu_r_resp, 2'b00);

    // 2: word read at offset 4
    do_req(64'h8000_0004, 3'd2, 1'b0, 4'd1);
    do_ar(0, 64'h8000_0000, 8'd0, 3'd2, 4'd1);
    send_beat(SD, 2'b00, 1'b1, 4'd1);
    wait_done("t2");
    check_val("t2_data", cpu_r_data, 64'h11223344);

    // 2b: oversize request clamps to full width
    do_req(64'h8000_000B, 3'd5, 1'b0, 4'd3);
    do_ar(0, 64'h8000_0008, 8'd0, 3'd3, 4'd3);
    send_beat(SD, 2'b01, 1'b1, 4'd3);
    wait_done("t2b");
    check_val("t2b_data", cpu_r_data, 64'h0000001122334455);
    check_val("t2b_resp", cpu_r_resp, 2'b01);

    // 3: line refill, slow AR ready
    do_req(64'h8000_0038, 3'd0, 1'b1, 4'd2);
    do_ar(3, 64'h8000_0020, 8'd3, 3'd3, 4'd2);
    for (int k = 0; k < 4; k++) send_beat(64'hD0D0_0000_0000_0000 + 64'(k), 2'b00, k == 3, 4'd2);
    wait_done("t3");
    check_val("t3_line", cpu_r_line, {64'hD0D0_0000_0000_0003, 64'hD0D0_0000_0000_0002,
                                      64'hD0D0_0000_0000_0001, 64'hD0D0_0000_0000_0000});
    check_val("t3_resp", cpu_r_resp, 2'b00);
    check_val("t3_data_hold", cpu_r_data, 64'h0000001122334455);

    // 4: DECERR on beat 2
    do_req(64'h8000_0100, 3'd0, 1'b1, 4'd2);
    do_ar(0, 64'h8000_0100, 8'd3, 3'd3, 4'd2);
    for (int k = 0; k < 4; k++) send_beat(64'hE0 + 64'(k), (k == 2) ? 2'b11 : 2'b00, k == 3, 4'd2);
    wait_done("t4");
    check_val("t4_resp", cpu_r_resp, 2'b11);
    check_val("t4_line", cpu_r_line, {64'hE3, 64'hE2, 64'hE1, 64'hE0});

    // 5: early last forces SLVERR, slot 3 keeps old contents
    do_req(64'h8000_0140, 3'd0, 1'b1, 4'd4);
    do_ar(0, 64'h8000_0140, 8'd3, 3'd3, 4'd4);
    for (int k = 0; k < 3; k++) send_beat(64'hF0 + 64'(k), 2'b00, k == 2, 4'd4);
    wait_done("t5");
    check_val("t5_resp", cpu_r_resp, 2'b10);
    check_val("t5_line", cpu_r_line, {64'hE3, 64'hF2, 64'hF1, 64'hF0});

    // 5b: foreign-id last is ignored
    do_req(64'h8000_0180, 3'd0, 1'b1, 4'd5);
    do_ar(0, 64'h8000_0180, 8'd3, 3'd3, 4'd5);
    send_beat(64'hA0, 2'b00, 1'b0, 4'd5);
    send_beat(64'hBAD, 2'b11, 1'b1, 4'd6);
    check_val("t5b_no_early_done", cpu_r_valid, 1'b0);
    check_val("t5b_still_ready", axi_r_ready_o, 1'b1);
    for (int k = 1; k < 4; k++) send_beat(64'hA0 + 64'(k), 2'b00, k == 3, 4'd5);
    wait_done("t5b");
    check_val("t5b_line", cpu_r_line, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    check_val("t5b_resp", cpu_r_resp, 2'b00);

    // 6: async reset during data phase
    do_req(64'h8000_0200, 3'd0, 1'b1, 4'd2);
    do_ar(0, 64'h8000_0200, 8'd3, 3'd3, 4'd2);
    send_beat(64'hC0, 2'b00, 1'b0, 4'd2);
    #2 reset_n = 1'b0;
    #1;
    check_val("t6_r_ready", axi_r_ready_o, 1'b0);
    check_val("t6_line", cpu_r_line, 256'h0);
    check_val("t6_data", cpu_r_data, 64'h0);
    check_val("t6_resp", cpu_r_resp, 2'b00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_val("t6_no_pulse", cpu_r_valid, 1'b0);
    end
    reset_n = 1'b1;
    do_req(64'h8000_0006, 3'd1, 1'b0, 4'd7);
    do_ar(0, 64'h8000_0000, 8'd0, 3'd1, 4'd7);
    send_beat(SD, 2'b00, 1'b1, 4'd7);
    wait_done("t6");
    check_val("t6_after_data", cpu_r_data, 64'h1122);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
